// File: rtl/parity_check_sched.sv
// parity_check_sched: two-requester round-robin scheduler feeding a single
// shared parity evaluator. Each accepted 4-bit word {a,b,c,p} is evaluated
// one cycle after it is accepted. The result is then held with a valid/ready
// handshake until the consumer takes it. Failed checks are counted in a
// saturating error counter.
module parity_check_sched #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [3:0]       req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [3:0]       req1_data,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_ok,
    output logic             res_id,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic             last_q, last_d;   // requester granted most recently
    logic [3:0]       word_q, word_d;   // word captured at accept time
    logic             id_q, id_d;       // owner of the captured word
    logic             ok_q, ok_d;       // registered parity verdict
    logic [CNT_W-1:0] err_q, err_d;

    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             res_hs;

    // Even parity over {a,b,c,p}: the word is good when the XOR of all bits is 0.
    function automatic logic parity_ok(input logic [3:0] word);
        return ~(^word);
    endfunction

    // Saturating error count update; a clear always overrides an increment.
    function automatic logic [CNT_W-1:0] err_next(
        input logic [CNT_W-1:0] cnt,
        input logic             clr,
        input logic             inc
    );
        if (clr) begin
            return '0;
        end
        if (inc && (cnt != CNT_MAX)) begin
            return cnt + CNT_W'(1);
        end
        return cnt;
    endfunction

    // Round-robin grant in IDLE; readies are held low while reset is asserted
    // so nothing can be accepted before the first edge with rst_n high.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && (state_q == IDLE)) begin
            if (req0_valid && (!req1_valid || last_q)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign accept = grant0 | grant1;
    assign res_hs = (state_q == RESP) && res_ready;

    // Next-state, capture and evaluation logic of the scheduler FSM.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        word_d  = word_q;
        id_d    = id_q;
        ok_d    = ok_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    word_d  = grant0 ? req0_data : req1_data;
                    id_d    = grant1;
                    last_d  = grant1;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                ok_d    = parity_ok(word_q);
                state_d = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Error counter update on result handshakes that report a failure.
    always_comb begin
        err_d = err_next(err_q, err_clr, res_hs && !ok_q);
    end

    // State and datapath registers; reset discards any pending word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            word_q  <= 4'd0;
            id_q    <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            word_q  <= word_d;
            id_q    <= id_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign res_valid  = (state_q == RESP);
    assign res_ok     = ok_q;
    assign res_id     = id_q;
    assign err_cnt    = err_q;
    assign busy       = (state_q != IDLE);

endmodule
